// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM state encoding,
// event field widths and the packed entry width helper.
package pipe_trace_buffer_pkg;

  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Packed entry layout is {cycle, pc, rd, data}, MSB first.
  function automatic int entry_w(input int cnt_w, input int pc_w, input int xlen);
    return cnt_w + pc_w + RD_W + xlen;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace entry storage: synchronous write, asynchronous read so the head
// entry is visible show-ahead on the read port.
module pipe_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// On-chip trace buffer for retired write-back events with a PC-match trigger,
// a post-trigger capture window and a show-ahead drain port.
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ev_valid,
  input  logic [PC_W-1:0]  ev_pc,
  input  logic [4:0]       ev_rd,
  input  logic [XLEN-1:0]  ev_data,
  input  logic             mode,
  input  logic             trig_arm,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [AW:0]      post_cnt,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_cycle,
  output logic [PC_W-1:0]  rd_pc,
  output logic [4:0]       rd_rd,
  output logic [XLEN-1:0]  rd_data,
  output logic [AW:0]      count,
  output logic [1:0]       state,
  output logic             overflow
);

  localparam int EW = entry_w(CNT_W, PC_W, XLEN);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_state_e     st_q, st_d;
  logic [AW:0]      rem_q, rem_d;
  logic [AW-1:0]    head_q, tail_q;
  logic [AW:0]      cnt_q;
  logic [CNT_W-1:0] cyc_q;
  logic             ovf_q;
  logic             capture, pop, full, trig_hit, we;
  logic [EW-1:0]    wentry, hentry;

  // Read handshake: the head entry is offered whenever rd_valid is high and
  // is consumed on the rising edge where rd_valid && rd_ready.
  assign rd_valid = (cnt_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (cnt_q == FULL_CNT);
  assign capture  = ev_valid && en && (st_q == ST_ARMED || st_q == ST_POST);
  assign trig_hit = capture && (st_q == ST_ARMED) && (ev_pc == trig_pc);
  // A full stop-when-full buffer only accepts a write when a pop frees a slot.
  assign we       = capture && !trig_arm && (!full || pop || !mode);
  assign wentry   = {cyc_q, ev_pc, ev_rd, ev_data};

  pipe_trace_buffer_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (tail_q),
    .wdata (wentry),
    .raddr (head_q),
    .rdata (hentry)
  );

  assign {rd_cycle, rd_pc, rd_rd, rd_data} = rd_valid ? hentry : '0;
  assign count    = cnt_q;
  assign state    = st_q;
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_IDLE;
      rem_q <= '0;
    end else begin
      st_q  <= st_d;
      rem_q <= rem_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    rem_d = rem_q;
    if (trig_arm) begin
      st_d  = ST_ARMED;
      rem_d = '0;
    end else begin
      case (st_q)
        ST_ARMED: begin
          if (trig_hit) begin
            if (post_cnt == '0) begin
              st_d = ST_DONE;
            end else begin
              st_d  = ST_POST;
              rem_d = post_cnt;
            end
          end
        end
        ST_POST: begin
          if (capture) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == 1) st_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (trig_arm) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (we) tail_q <= tail_q + 1'b1;
        // Wrap mode overwrites the oldest entry, so the head moves past it.
        if (pop || (capture && full && !mode)) head_q <= head_q + 1'b1;
        if (capture && full && !pop) ovf_q <= 1'b1;
        if (pop && !capture) cnt_q <= cnt_q - 1'b1;
        else if (capture && !pop && !full) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: vector table for the trigger window,
// hand-written sequences for wrap/stop modes, same-edge pop and async reset.
module tb_pipe_trace_buffer;

  logic        clk;
  logic        reset;
  logic        en;
  logic        ev_valid;
  logic [63:0] ev_pc;
  logic [4:0]  ev_rd;
  logic [63:0] ev_data;
  logic        mode;
  logic        trig_arm;
  logic [63:0] trig_pc;
  logic [4:0]  post_cnt;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_cycle;
  logic [63:0] rd_pc;
  logic [4:0]  rd_rd;
  logic [63:0] rd_data;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        arm;
    logic        en;
    logic        ev;
    logic [63:0] pc;
    logic [4:0]  exp_cnt;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vt[9];

  pipe_trace_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ev_valid (ev_valid),
    .ev_pc    (ev_pc),
    .ev_rd    (ev_rd),
    .ev_data  (ev_data),
    .mode     (mode),
    .trig_arm (trig_arm),
    .trig_pc  (trig_pc),
    .post_cnt (post_cnt),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_cycle (rd_cycle),
    .rd_pc    (rd_pc),
    .rd_rd    (rd_rd),
    .rd_data  (rd_data),
    .count    (count),
    .state    (state),
    .overflow (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rd_of(input logic [63:0] pc);
    return pc[6:2];
  endfunction

  function automatic logic [63:0] data_of(input logic [63:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [63:0] tp, input logic [4:0] pcnt);
    trig_pc  = tp;
    post_cnt = pcnt;
    trig_arm = 1'b1;
    tick();
    trig_arm = 1'b0;
  endtask

  task automatic set_ev(input logic v, input logic [63:0] pc);
    ev_valid = v;
    ev_pc    = pc;
    ev_rd    = rd_of(pc);
    ev_data  = data_of(pc);
  endtask

  task automatic send(input logic [63:0] pc);
    set_ev(1'b1, pc);
    tick();
    set_ev(1'b0, 64'h0);
  endtask

  // Scoreboard drain: entries must come out in exp_q order with stamps one apart.
  task automatic drain();
    logic [63:0] e;
    logic [31:0] prev;
    bit          first;
    first    = 1'b1;
    prev     = '0;
    rd_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain_valid", {63'd0, rd_valid}, 64'd1);
      check("drain_pc", rd_pc, e);
      check("drain_rd", {59'd0, rd_rd}, {59'd0, rd_of(e)});
      check("drain_data", rd_data, data_of(e));
      if (!first) check("drain_stamp", {32'd0, rd_cycle}, {32'd0, prev + 32'd1});
      prev  = rd_cycle;
      first = 1'b0;
      tick();
    end
    rd_ready = 1'b0;
    check("drain_empty_count", {59'd0, count}, 64'd0);
    check("drain_empty_valid", {63'd0, rd_valid}, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1; mode = 1'b0; trig_arm = 1'b0; trig_pc = '0; post_cnt = '0; rd_ready = 1'b0;
    set_ev(1'b0, 64'h0);

    // 1: reset, events while IDLE are ignored
    tick(); tick();
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_count", {59'd0, count}, 64'd0);
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_rd_pc", rd_pc, 64'd0);
    reset = 1'b1;
    tick();
    send(64'h40); send(64'h44); send(64'h48);
    check("idle_count", {59'd0, count}, 64'd0);
    check("idle_state", {62'd0, state}, 64'd0);

    // 2: trigger window, table-driven
    trig_pc = 64'h10; post_cnt = 5'd3; mode = 1'b0;
    vt[0] = '{arm:1'b1, en:1'b1, ev:1'b1, pc:64'h10, exp_cnt:5'd0, exp_st:2'd1};
    vt[1] = '{arm:1'b0, en:1'b0, ev:1'b1, pc:64'h10, exp_cnt:5'd0, exp_st:2'd1};
    vt[2] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h00, exp_cnt:5'd1, exp_st:2'd1};
    vt[3] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h04, exp_cnt:5'd2, exp_st:2'd1};
    vt[4] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h10, exp_cnt:5'd3, exp_st:2'd2};
    vt[5] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h14, exp_cnt:5'd4, exp_st:2'd2};
    vt[6] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h18, exp_cnt:5'd5, exp_st:2'd2};
    vt[7] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h1C, exp_cnt:5'd6, exp_st:2'd3};
    vt[8] = '{arm:1'b0, en:1'b1, ev:1'b1, pc:64'h20, exp_cnt:5'd6, exp_st:2'd3};
    for (int i = 0; i < 9; i++) begin
      trig_arm = vt[i].arm;
      en       = vt[i].en;
      set_ev(vt[i].ev, vt[i].pc);
      tick();
      check($sformatf("vec%0d_count", i), {59'd0, count}, {59'd0, vt[i].exp_cnt});
      check($sformatf("vec%0d_state", i), {62'd0, state}, {62'd0, vt[i].exp_st});
    end
    trig_arm = 1'b0; en = 1'b1;
    set_ev(1'b0, 64'h0);
    check("win_ovf", {63'd0, overflow}, 64'd0);
    exp_q = '{64'h00, 64'h04, 64'h10, 64'h14, 64'h18, 64'h1C};
    drain();

    // 3a: wrap mode, 20 events into 16 slots keeps the newest 16
    mode = 1'b0;
    arm(64'hFFFF_0000, 5'd0);
    for (int i = 0; i < 20; i++) send(64'(i * 4));
    check("wrap_count", {59'd0, count}, 64'd16);
    check("wrap_ovf", {63'd0, overflow}, 64'd1);
    check("wrap_state", {62'd0, state}, 64'd1);
    for (int i = 4; i < 20; i++) exp_q.push_back(64'(i * 4));
    drain();

    // 3b: stop-when-full keeps the oldest 16; arm clears overflow
    mode = 1'b1;
    arm(64'hFFFF_0000, 5'd0);
    check("arm_clr_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 0; i < 20; i++) send(64'(i * 4));
    check("stop_count", {59'd0, count}, 64'd16);
    check("stop_ovf", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'(i * 4));
    drain();

    // 4: full buffer, capture and pop on the same edge
    mode = 1'b0;
    arm(64'hFFFF_0000, 5'd0);
    for (int i = 0; i < 16; i++) send(64'(i * 4));
    check("full_count", {59'd0, count}, 64'd16);
    check("full_head", rd_pc, 64'h0);
    set_ev(1'b1, 64'h100);
    rd_ready = 1'b1;
    tick();
    set_ev(1'b0, 64'h0);
    rd_ready = 1'b0;
    check("same_edge_count", {59'd0, count}, 64'd16);
    check("same_edge_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 1; i < 16; i++) exp_q.push_back(64'(i * 4));
    exp_q.push_back(64'h100);
    drain();

    // 5: post_cnt=0, trigger on first event; empty capture with rd_ready held
    arm(64'h40, 5'd0);
    rd_ready = 1'b1;
    send(64'h40);
    rd_ready = 1'b0;
    check("p0_state", {62'd0, state}, 64'd3);
    check("p0_count", {59'd0, count}, 64'd1);
    check("p0_head", rd_pc, 64'h40);
    send(64'h44);
    check("done_no_capture", {59'd0, count}, 64'd1);
    arm(64'h40, 5'd0);
    check("rearm_count", {59'd0, count}, 64'd0);
    check("rearm_state", {62'd0, state}, 64'd1);
    check("rearm_valid", {63'd0, rd_valid}, 64'd0);

    // 6: asynchronous reset in the middle of POST
    arm(64'h0, 5'd8);
    send(64'h0); send(64'h4); send(64'h8); send(64'hC); send(64'h10);
    check("post_state", {62'd0, state}, 64'd2);
    check("post_count", {59'd0, count}, 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", {62'd0, state}, 64'd0);
    check("async_count", {59'd0, count}, 64'd0);
    check("async_valid", {63'd0, rd_valid}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
